setassoc_cache: RTL and testbench

Parametrised set-associative, write-back, write-allocate cache with true-LRU replacement, sitting between a requesting client (CPU side or lower-level cache) and the next level of the memory hierarchy. It accepts single-word read/write requests, hits in two cycles, and on a miss writes back a dirty victim line word by word before filling the new line from the next level. It generalises the earlier fixed-geometry cache with configurable sets, ways, line length and word width, real LRU, and an invalidate-all command.

---
 rtl/setassoc_cache.sv | 278 +++++++++++++++++++++++++++
 tb/tb_setassoc_cache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/setassoc_cache.sv
// Set-associative write-back/write-allocate cache with true-LRU replacement.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module setassoc_cache #(
  parameter int SETS      = 4,
  parameter int WAYS      = 2,
  parameter int LINEWORDS = 4,
  parameter int ADDRBITS  = 16,
  parameter int WORDBITS  = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [WORDBITS-1:0] wdata,
  output logic                ready,
  output logic                done,
  output logic [WORDBITS-1:0] rdata,
  input  logic                invalidate_all,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [WORDBITS-1:0] mem_wdata,
  input  logic [WORDBITS-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
`endif
  input  logic                mem_ack
);
  localparam int OFFB = $clog2(LINEWORDS);
  localparam int IDXB = $clog2(SETS);
  localparam int WAYB = $clog2(WAYS);
  localparam int TAGB = ADDRBITS - OFFB - IDXB;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;
  typedef struct packed {
    logic                we;
    logic [ADDRBITS-1:0] addr;
    logic [WORDBITS-1:0] wdata;
  } req_t;
  typedef logic [SETS-1:0][WAYS-1:0][WAYB-1:0] age_t;

  function automatic age_t age_init();
    age_t a;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        a[s][w] = WAYB'(w);
    return a;
  endfunction

  state_t                              state_q, state_d;
  req_t                                req_q, req_d;
  logic [WAYB-1:0]                     way_q, way_d;
  logic [OFFB-1:0]                     cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0]           valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][TAGB-1:0] tag_q, tag_d;
  age_t                                age_q, age_d;
  logic                                done_q, done_d;
  logic [WORDBITS-1:0]                 rdata_q, rdata_d;
  logic                                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDRBITS-1:0]                 mem_addr_q, mem_addr_d;
  logic [WORDBITS-1:0]                 mem_wdata_q, mem_wdata_d;
`ifdef CACHE_STATS_EN
  logic [31:0]                         hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
`endif

  logic [WORDBITS-1:0] data_mem [SETS][WAYS][LINEWORDS];
  logic                dwe;
  logic [WAYB-1:0]     dway;
  logic [OFFB-1:0]     doff;
  logic [WORDBITS-1:0] dval;

  logic [IDXB-1:0] idx;
  logic [TAGB-1:0] tag;
  logic [OFFB-1:0] off;
  logic [OFFB-1:0] cnt_nx;
  logic            cnt_last;
  assign idx      = req_q.addr[OFFB +: IDXB];
  assign tag      = req_q.addr[ADDRBITS-1 -: TAGB];
  assign off      = req_q.addr[OFFB-1:0];
  assign cnt_nx   = cnt_q + 1'b1;
  assign cnt_last = (cnt_q == OFFB'(LINEWORDS - 1));

  logic            hit, inv_found;
  logic [WAYB-1:0] hit_way, victim;
  logic [WAYB-1:0] old_age;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
        hit     = 1'b1;
        hit_way = WAYB'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        victim    = WAYB'(w);
      end
    end
    // With every way valid the ages form a permutation, so exactly one is oldest.
    if (!inv_found)
      for (int w = 0; w < WAYS; w++)
        if (age_q[idx][w] == WAYB'(WAYS - 1)) victim = WAYB'(w);
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    age_d       = age_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dwe         = 1'b0;
    dway        = way_q;
    doff        = cnt_q;
    dval        = mem_rdata;
    old_age     = age_q[idx][way_q];
`ifdef CACHE_STATS_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (invalidate_all) begin
          valid_d = '0;
          dirty_d = '0;
          age_d   = age_init();
        end else if (req) begin
          req_d   = '{we: we, addr: addr, wdata: wdata};
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
`ifdef CACHE_STATS_EN
        if (hit) hit_cnt_d = hit_cnt_q + 1'b1;
        else     miss_cnt_d = miss_cnt_q + 1'b1;
`endif
        if (hit) begin
          way_d   = hit_way;
          state_d = S_RESP;
          done_d  = 1'b1;
          rdata_d = req_q.we ? req_q.wdata : data_mem[idx][hit_way][off];
        end else begin
          way_d     = victim;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (dirty_q[idx][victim]) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx][victim], idx, OFFB'(0)};
            mem_wdata_d = data_mem[idx][victim][0];
          end else begin
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, OFFB'(0)};
          end
        end
      end
      S_WB: begin
        if (mem_req_q && mem_ack) begin
          if (cnt_last) begin
            cnt_d      = '0;
            state_d    = S_FILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, OFFB'(0)};
          end else begin
            cnt_d       = cnt_nx;
            mem_addr_d  = {tag_q[idx][way_q], idx, cnt_nx};
            mem_wdata_d = data_mem[idx][way_q][cnt_nx];
          end
        end
      end
      S_FILL: begin
        if (mem_req_q && mem_ack) begin
          dwe = 1'b1;
          if (cnt_last) begin
            mem_req_d           = 1'b0;
            tag_d[idx][way_q]   = tag;
            valid_d[idx][way_q] = 1'b1;
            dirty_d[idx][way_q] = 1'b0;
            state_d             = S_RESP;
            done_d              = 1'b1;
            // The last word is still on mem_rdata, not yet in the array.
            rdata_d = req_q.we ? req_q.wdata :
                      (off == cnt_q) ? mem_rdata : data_mem[idx][way_q][off];
          end else begin
            cnt_d      = cnt_nx;
            mem_addr_d = {tag, idx, cnt_nx};
          end
        end
      end
      S_RESP: begin
        if (req_q.we) begin
          dwe                 = 1'b1;
          doff                = off;
          dval                = req_q.wdata;
          dirty_d[idx][way_q] = 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
          if (WAYB'(w) == way_q)           age_d[idx][w] = '0;
          else if (age_q[idx][w] < old_age) age_d[idx][w] = age_q[idx][w] + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '0;
      age_q       <= age_init();
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      age_q       <= age_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (dwe) data_mem[idx][dway][doff] <= dval;
  end

  assign ready     = (state_q == S_IDLE) && !invalidate_all;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef CACHE_STATS_EN
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_setassoc_cache.sv
// Scoreboard bench for setassoc_cache: a timestamp-LRU line model predicts read data
// and the exact next-level word traffic; a monitor and a memory responder check them.
module tb_setassoc_cache;
  localparam int S = 4, W = 2, LW = 4;

  logic        clock = 0, reset = 1, req = 0, we = 0, invalidate_all = 0;
  logic [15:0] addr = 0;
  logic [31:0] wdata = 0;
  logic        ready, done, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = 0;
  logic        mem_ack = 0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  int          ref_hits = 0, ref_misses = 0;
`endif

  setassoc_cache dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .invalidate_all(invalidate_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_ack(mem_ack));

  always #5 clock = ~clock;

  typedef struct packed { logic we; logic [15:0] addr; logic [31:0] wdata; } mop_t;
  typedef struct { logic [31:0] rd; bit hit; int acc; } exp_t;
  mop_t mop_q[$];
  exp_t exp_q[$];

  int total = 0, passed = 0, cyc = 0, rd_acks = 0, wait_cnt = 0;
  longint tick = 0;

  // Next-level memory contents and the model's view of resident lines.
  logic [31:0] bmem [logic [15:0]];
  bit          rv [S][W];
  bit          rdty [S][W];
  int          rtag [S][W];
  longint      rstamp [S][W];
  logic [31:0] rdat [S][W][LW];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic fail(string nm);
    total++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] bget(logic [15:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'h5A00_0000 + 32'(a) * 3;
  endfunction

  task automatic ref_clear();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin rv[s][w] = 0; rdty[s][w] = 0; end
  endtask

  task automatic ref_access(input bit is_wr, input logic [15:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output bit hit);
    int s, t, o, way;
    s = int'(a) / LW % S;
    t = int'(a) / (LW * S);
    o = int'(a) % LW;
    way = -1;
    for (int w = 0; w < W; w++) if (rv[s][w] && rtag[s][w] == t) way = w;
    hit = (way >= 0);
    if (!hit) begin
      for (int w = W - 1; w >= 0; w--) if (!rv[s][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < W; w++) if (rstamp[s][w] < rstamp[s][way]) way = w;
      end
      if (rv[s][way] && rdty[s][way])
        for (int i = 0; i < LW; i++)
          mop_q.push_back('{1'b1, 16'(rtag[s][way] * LW * S + s * LW + i), rdat[s][way][i]});
      for (int i = 0; i < LW; i++) begin
        mop_q.push_back('{1'b0, 16'(t * LW * S + s * LW + i), 32'h0});
        rdat[s][way][i] = bget(16'(t * LW * S + s * LW + i));
      end
      rv[s][way] = 1; rdty[s][way] = 0; rtag[s][way] = t;
    end
    if (is_wr) begin
      rdat[s][way][o] = d;
      rdty[s][way] = 1;
    end
    exp_rd = rdat[s][way][o];
    tick++;
    rstamp[s][way] = tick;
`ifdef CACHE_STATS_EN
    if (hit) ref_hits++; else ref_misses++;
`endif
  endtask

  // Next-level memory: random wait, one-cycle ack, occasional stray ack when idle.
  always @(negedge clock) begin
    if (mem_ack) begin
      mem_ack = 0;
      wait_cnt = $urandom_range(0, 3);
    end else if (reset) begin
      mem_ack = 0;
    end else if (mem_req) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        mop_t m;
        mem_ack = 1;
        if (mop_q.size() == 0) fail("mem_unexpected_op");
        else begin
          m = mop_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_addr", 32'(mem_addr), 32'(m.addr));
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else begin mem_rdata = bget(mem_addr); rd_acks++; end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack = 1;
      mem_rdata = $urandom;
    end
  end

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) fail("spurious_done");
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", rdata, e.rd);
        if (e.hit) chk("hit_latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  task automatic issue(bit w, logic [15:0] a, logic [31:0] d, bit wait_done);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!ready && n < 500) begin @(negedge clock); n++; end
    if (!ready) begin fail("ready_timeout"); return; end
    req = 1; we = w; addr = a; wdata = d;
    ref_access(w, a, d, e.rd, e.hit);
    e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clock);
    req = 0;
    if (wait_done) begin
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(negedge clock); n++; end
      if (exp_q.size() != 0) begin
        fail("done_timeout");
        exp_q.delete(); mop_q.delete();
      end else if (mop_q.size() != 0) begin
        fail("mem_ops_missing");
        mop_q.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    exp_q.delete(); mop_q.delete(); ref_clear();
`ifdef CACHE_STATS_EN
    ref_hits = 0; ref_misses = 0;
`endif
    @(negedge clock);
    reset = 0;
  endtask

  task automatic do_inval(bit with_req);
    @(negedge clock);
    invalidate_all = 1; req = with_req; addr = 16'h0013; we = 0;
    #1 chk("ready_during_inval", 32'(ready), 32'd0);
    ref_clear();
    @(negedge clock);
    invalidate_all = 0; req = 0;
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < 4; i++) bmem[16'(16 + i)] = 32'hA0 + i;
    ref_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
`endif
    reset = 0;

    issue(0, 16'h0010, 0, 1);
    issue(0, 16'h0011, 0, 1);
    issue(1, 16'h0012, 32'hDEADBEEF, 1);
    issue(0, 16'h0012, 0, 1);
    issue(0, 16'h0020, 0, 1);
    issue(0, 16'h0030, 0, 1);

    do_reset();
    issue(0, 16'h0010, 0, 1);
    issue(0, 16'h0020, 0, 1);
    issue(0, 16'h0010, 0, 1);
    issue(0, 16'h0030, 0, 1);
    issue(0, 16'h0010, 0, 1);

    issue(1, 16'h0012, 32'h1234_5678, 1);
    do_inval(1);
    repeat (3) @(negedge clock);
    issue(0, 16'h0012, 0, 1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) do_inval($urandom_range(0, 1) == 1);
      else issue($urandom_range(0, 2) == 0, 16'($urandom_range(0, 127)), $urandom, 1);
    end
`ifdef CACHE_STATS_EN
    @(negedge clock);
    chk("hit_count", hit_count, 32'(ref_hits));
    chk("miss_count", miss_count, 32'(ref_misses));
`endif

    do_reset();
    base = rd_acks;
    issue(0, 16'h0050, 0, 0);
    n = 0;
    while (rd_acks < base + 2 && n < 500) begin @(negedge clock); n++; end
    if (rd_acks < base + 2) fail("fill_ack_timeout");
    reset = 1;
    exp_q.delete(); mop_q.delete(); ref_clear();
    @(negedge clock);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
`ifdef CACHE_STATS_EN
    chk("midrst_hits", hit_count, 32'd0);
    chk("midrst_misses", miss_count, 32'd0);
    ref_hits = 0; ref_misses = 0;
`endif
    reset = 0;
    repeat (6) @(negedge clock);
    issue(0, 16'h0050, 0, 1);
    issue(0, 16'h0052, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
